jk_checker: RTL and testbench
=============================

Name: jk_checker

Overview:
- Self-checking monitor for the myjk flip-flop (active-low J, K and clock inputs; Q and INVQ outputs).
- Runs on its own clock and observes the signals that drive the flip-flop and the signals it produces.
- At each active edge of the flip-flop's clock, it captures the command and later compares Q and INVQ against the JK characteristic.
- Reports per-edge mismatches, running counts and a sticky fail flag, for the lab board and for benches.

Parameters:
- SETTLE, default 2: CP cycles waited after a detected active edge before Q/INVQ are compared (1..15).
- CNT_W, default 8: width of the check and error counters.

Ports:
- CP  in  1  checker clock, rising-edge.
- INVCLR  in  1  asynchronous active-low reset.
- INVCP_MON  in  1  observed flip-flop clock (active-low; active edge = falling edge of INVCP_MON).
- INVJ_MON  in  1  observed active-low J.
- INVK_MON  in  1  observed active-low K.
- Q_MON  in  1  observed Q.
- INVQ_MON  in  1  observed INVQ.
- EN  in  1  checking enable; edges seen while EN=0 are ignored.
- ERR  out  1  one-cycle pulse on a mismatch.
- FAIL  out  1  sticky; set by any mismatch.
- MODE  out  2  last captured command: 00 hold, 01 reset, 10 set, 11 toggle.
- CHK_CNT  out  CNT_W  number of checks performed, saturating.
- ERR_CNT  out  CNT_W  number of mismatches, saturating.

Behaviour:
- Reset (INVCLR=0, asynchronous):
  - ERR=0, FAIL=0, MODE=00, CHK_CNT=0, ERR_CNT=0, FSM=IDLE.
  - Synchronizer stages cleared to 1 (the inactive level of INVCP_MON).
- Input synchronization: all five _MON inputs pass through 2-flop synchronizers on CP.
- Edge detection:
  - An active edge is detected when the synced INVCP_MON was 1 last cycle and is 0 this cycle.
  - Detection latency is 3 CP cycles from the input transition.
- Decode at detection (J=~INVJ, K=~INVK):
  - J=0,K=0 hold (00).
  - J=0,K=1 reset (01).
  - J=1,K=0 set (10).
  - J=1,K=1 toggle (11).
- FSM:
  - IDLE: on an active edge with EN=1, latch MODE and QPREV (the synced Q_MON value on the detecting cycle, i.e. the pre-edge Q), load the wait counter with SETTLE, and go to WAIT.
  - WAIT: decrement the counter each cycle. At 0, go to CHECK.
  - CHECK: one cycle. Compute expected Q: hold → QPREV, reset → 0, set → 1, toggle → ~QPREV. A mismatch is either:
    - synced Q_MON != expected, or
    - synced INVQ_MON != ~synced Q_MON.
    Then:
    - CHK_CNT increments.
    - On a mismatch: ERR=1 for this cycle, ERR_CNT increments, FAIL is set.
    - Return to IDLE.
- Counters saturate at all-ones and never wrap.
- FAIL clears only on reset.
- An active edge arriving during WAIT or CHECK is not checked. That edge is dropped; it does not increment CHK_CNT.
- EN is sampled only in IDLE. Deasserting EN in WAIT does not cancel a pending check.
- ERR is registered and rises on the cycle after the FSM enters CHECK.
- Asserting INVCLR mid-WAIT aborts the pending check. No count update occurs.
- SETTLE=0 is illegal. The implementation clamps it to 1.

Test Plan:
- Reset then toggle: INVCLR low, then high; INVJ=INVK=0 with Q following a correct JK model, 4 falling edges of INVCP_MON 20 CP cycles apart → CHK_CNT=4, ERR_CNT=0, FAIL=0, MODE=11.
- Full command sweep with a correct model: reset, hold, set, toggle, one edge each → MODE follows 01,00,10,11; no ERR pulse; CHK_CNT=4.
- Fault injection: set command (INVJ=0, INVK=1) with Q forced to 0 → ERR pulses exactly once, ERR_CNT=1, FAIL=1. FAIL remains 1 after 10 further correct edges.
- Complement fault: Q correct but INVQ_MON=Q_MON → ERR_CNT increments once per edge.
- Saturation and dropped edges: CNT_W=2, 5 faulty edges → ERR_CNT=3, CHK_CNT=3. Then 2 edges 1 CP cycle apart (second edge lands in WAIT) → CHK_CNT stays at 3.
- EN=0 for 3 edges → CHK_CNT unchanged. INVCLR pulsed low during WAIT → all outputs return to 0 immediately.

Source files
------------

// File: rtl/jk_checker.sv
// rtl/jk_checker.sv - sampled-clock monitor checking a myjk flip-flop against the JK table
module jk_checker #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             CP,
  input  logic             INVCLR,
  input  logic             INVCP_MON,
  input  logic             INVJ_MON,
  input  logic             INVK_MON,
  input  logic             Q_MON,
  input  logic             INVQ_MON,
  input  logic             EN,
  output logic             ERR,
  output logic             FAIL,
  output logic [1:0]       MODE,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  // A zero settle time would skip WAIT entirely; the wait counter is 4 bits.
  localparam int         SETTLE_CL = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Bit order of the synchronizer vectors: {invcp, invj, invk, q, invq}
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic             r_cp_d;
  logic             r_q_d;
  logic [3:0]       r_wait;
  logic             r_qprev;
  logic [1:0]       r_mode;
  logic             r_err;
  logic             r_fail;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_cp_s;
  logic w_j;
  logic w_k;
  logic w_q_s;
  logic w_invq_s;
  logic w_edge;
  logic w_load;
  logic w_dec;
  logic w_check;
  logic w_exp_q;
  logic w_mismatch;

  assign w_cp_s   = r_sync2[4];
  assign w_j      = ~r_sync2[3];
  assign w_k      = ~r_sync2[2];
  assign w_q_s    = r_sync2[1];
  assign w_invq_s = r_sync2[0];

  // Falling edge of the observed flip-flop clock, seen one cycle after the synchronizer.
  assign w_edge = r_cp_d & ~w_cp_s;

  // Two-flop synchronizers plus one delay stage; r_q_d is Q aligned with r_cp_d,
  // so on the detecting cycle it still holds the value from before the edge.
  always_ff @(posedge CP or negedge INVCLR) begin
    if (!INVCLR) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_cp_d  <= 1'b1;
      r_q_d   <= 1'b1;
    end else begin
      r_sync1 <= {INVCP_MON, INVJ_MON, INVK_MON, Q_MON, INVQ_MON};
      r_sync2 <= r_sync1;
      r_cp_d  <= r_sync2[4];
      r_q_d   <= r_sync2[1];
    end
  end

  // FSM state register.
  always_ff @(posedge CP or negedge INVCLR) begin
    if (!INVCLR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath strobes; edges outside IDLE are dropped.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    w_check = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge && EN) begin
          w_load = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_dec = 1'b1;
        if (r_wait <= 4'd1) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_check = 1'b1;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Expected Q from the captured command and the pre-edge Q.
  always_comb begin
    w_exp_q = r_qprev;
    case (r_mode)
      2'b00:   w_exp_q = r_qprev;
      2'b01:   w_exp_q = 1'b0;
      2'b10:   w_exp_q = 1'b1;
      default: w_exp_q = ~r_qprev;
    endcase
  end

  assign w_mismatch = (w_q_s != w_exp_q) | (w_invq_s == w_q_s);

  // Command capture, settle countdown, result flags and saturating counters.
  always_ff @(posedge CP or negedge INVCLR) begin
    if (!INVCLR) begin
      r_wait    <= 4'd0;
      r_qprev   <= 1'b0;
      r_mode    <= 2'b00;
      r_err     <= 1'b0;
      r_fail    <= 1'b0;
      r_chk_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_load) begin
        r_mode  <= {w_j, w_k};
        r_qprev <= r_q_d;
        r_wait  <= SETTLE_LD;
      end else if (w_dec) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_check) begin
        if (r_chk_cnt != '1) begin
          r_chk_cnt <= r_chk_cnt + 1'b1;
        end
        if (w_mismatch) begin
          r_err  <= 1'b1;
          r_fail <= 1'b1;
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign ERR     = r_err;
  assign FAIL    = r_fail;
  assign MODE    = r_mode;
  assign CHK_CNT = r_chk_cnt;
  assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_jk_checker.sv
// tb/tb_jk_checker.sv - scoreboard bench for jk_checker
module tb_jk_checker;

  logic cp = 1'b0;
  logic invclr = 1'b0;
  logic invcp = 1'b1;
  logic invj = 1'b1;
  logic invk = 1'b1;
  logic q_mon = 1'b0;
  logic invq_mon = 1'b1;
  logic en = 1'b1;

  logic       err;
  logic       fl;
  logic [1:0] mode;
  logic [7:0] chk_cnt;
  logic [7:0] err_cnt;

  logic       s_err;
  logic       s_fl;
  logic [1:0] s_mode;
  logic [1:0] s_chk;
  logic [1:0] s_errc;

  int n_pass = 0;
  int n_total = 0;

  bit         exp_q[$];
  bit         sb_e;
  bit         mon_on = 1'b0;
  logic [7:0] last_chk = 8'd0;
  logic       q_obs = 1'b0;

  jk_checker #(.SETTLE(2), .CNT_W(8)) dut (
    .CP(cp), .INVCLR(invclr), .INVCP_MON(invcp), .INVJ_MON(invj), .INVK_MON(invk),
    .Q_MON(q_mon), .INVQ_MON(invq_mon), .EN(en),
    .ERR(err), .FAIL(fl), .MODE(mode), .CHK_CNT(chk_cnt), .ERR_CNT(err_cnt)
  );

  jk_checker #(.SETTLE(2), .CNT_W(2)) dut_s (
    .CP(cp), .INVCLR(invclr), .INVCP_MON(invcp), .INVJ_MON(invj), .INVK_MON(invk),
    .Q_MON(q_mon), .INVQ_MON(invq_mon), .EN(en),
    .ERR(s_err), .FAIL(s_fl), .MODE(s_mode), .CHK_CNT(s_chk), .ERR_CNT(s_errc)
  );

  always #5 cp = ~cp;

  // Scoreboard: every completed check on the main instance pops one expected ERR value.
  always @(negedge cp) begin
    if (mon_on) begin
      if (chk_cnt !== last_chk) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_check chk_cnt=%0d required no check", chk_cnt);
        end else begin
          sb_e = exp_q.pop_front();
          if (err !== sb_e) $display("FAIL sb_err got=%b required=%b", err, sb_e);
          else n_pass++;
        end
        last_chk = chk_cnt;
      end else if (err !== 1'b0) begin
        n_total++;
        $display("FAIL sb_spurious_err got=%b required=0", err);
      end
    end
  end

  task automatic do_reset();
    mon_on = 1'b0;
    invclr = 1'b0;
    invcp = 1'b1; invj = 1'b1; invk = 1'b1;
    q_mon = 1'b0; invq_mon = 1'b1; q_obs = 1'b0; en = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge cp);
    invclr = 1'b1;
    repeat (2) @(negedge cp);
    last_chk = chk_cnt;
    mon_on = 1'b1;
  endtask

  // Acts as the flip-flop: applies J/K, makes the falling clock edge and updates Q.
  task automatic ff_edge(input logic jn, input logic kn, input bit force_en, input logic force_val,
                         input bit comp_fault, input bit checked);
    logic j, k, nq, qa;
    bit   e;
    @(negedge cp);
    invj = jn; invk = kn;
    repeat (3) @(negedge cp);
    j = ~jn; k = ~kn;
    case ({j, k})
      2'b00:   nq = q_obs;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = ~q_obs;
    endcase
    qa = force_en ? force_val : nq;
    e = (qa !== nq) || comp_fault;
    invcp = 1'b0;
    q_mon = qa;
    invq_mon = comp_fault ? qa : ~qa;
    q_obs = qa;
    if (checked) exp_q.push_back(e);
    repeat (10) @(negedge cp);
    invcp = 1'b1;
    repeat (6) @(negedge cp);
  endtask

  task automatic check_drained(input string tag);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL %s_sb_pending got=%0d required=0", tag, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    mon_on = 1'b0;
    invclr = 1'b0;
    #2;
    n_total++;
    if ({err, fl, mode, chk_cnt, err_cnt} !== 20'd0)
      $display("FAIL reset_main got=%h required=0", {err, fl, mode, chk_cnt, err_cnt});
    else n_pass++;
    n_total++;
    if ({s_err, s_fl, s_mode, s_chk, s_errc} !== 8'd0)
      $display("FAIL reset_sat got=%h required=0", {s_err, s_fl, s_mode, s_chk, s_errc});
    else n_pass++;
    do_reset();
    n_total++;
    if ({err, fl, mode, chk_cnt, err_cnt} !== 20'd0)
      $display("FAIL reset_release got=%h required=0", {err, fl, mode, chk_cnt, err_cnt});
    else n_pass++;
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 4; i++) ff_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (chk_cnt !== 8'd4) $display("FAIL toggle_chk got=%0d required=4", chk_cnt); else n_pass++;
    n_total++;
    if (err_cnt !== 8'd0) $display("FAIL toggle_errcnt got=%0d required=0", err_cnt); else n_pass++;
    n_total++;
    if (fl !== 1'b0) $display("FAIL toggle_sticky got=%b required=0", fl); else n_pass++;
    n_total++;
    if (mode !== 2'b11) $display("FAIL toggle_mode got=%b required=11", mode); else n_pass++;
    check_drained("toggle");
  endtask

  task automatic test_sweep();
    logic [1:0] cmds[4];
    cmds[0] = 2'b10; cmds[1] = 2'b11; cmds[2] = 2'b01; cmds[3] = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ff_edge(cmds[i][1], cmds[i][0], 1'b0, 1'b0, 1'b0, 1'b1);
      n_total++;
      if (mode !== ~cmds[i]) $display("FAIL sweep_mode%0d got=%b required=%b", i, mode, ~cmds[i]);
      else n_pass++;
    end
    n_total++;
    if (chk_cnt !== 8'd4) $display("FAIL sweep_chk got=%0d required=4", chk_cnt); else n_pass++;
    n_total++;
    if (err_cnt !== 8'd0) $display("FAIL sweep_errcnt got=%0d required=0", err_cnt); else n_pass++;
    check_drained("sweep");
  endtask

  task automatic test_fault();
    do_reset();
    ff_edge(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (err_cnt !== 8'd1) $display("FAIL fault_errcnt got=%0d required=1", err_cnt); else n_pass++;
    n_total++;
    if (fl !== 1'b1) $display("FAIL fault_sticky got=%b required=1", fl); else n_pass++;
    for (int i = 0; i < 10; i++) ff_edge(i[0], i[1], 1'b0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (fl !== 1'b1) $display("FAIL fault_sticky_hold got=%b required=1", fl); else n_pass++;
    n_total++;
    if (err_cnt !== 8'd1) $display("FAIL fault_errcnt_hold got=%0d required=1", err_cnt); else n_pass++;
    n_total++;
    if (chk_cnt !== 8'd11) $display("FAIL fault_chk got=%0d required=11", chk_cnt); else n_pass++;
    check_drained("fault");
  endtask

  task automatic test_complement();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ff_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_total++;
      if (err_cnt !== 8'(i + 1)) $display("FAIL comp_errcnt%0d got=%0d required=%0d", i, err_cnt, i + 1);
      else n_pass++;
    end
    check_drained("comp");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) ff_edge(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (s_errc !== 2'd3) $display("FAIL sat_errcnt got=%0d required=3", s_errc); else n_pass++;
    n_total++;
    if (s_chk !== 2'd3) $display("FAIL sat_chk got=%0d required=3", s_chk); else n_pass++;
    n_total++;
    if (err_cnt !== 8'd5) $display("FAIL sat_main_errcnt got=%0d required=5", err_cnt); else n_pass++;
    // Two hold edges one CP apart: the second lands while the first is settling.
    @(negedge cp);
    invj = 1'b1; invk = 1'b1;
    repeat (3) @(negedge cp);
    invcp = 1'b0;
    exp_q.push_back(1'b0);
    @(negedge cp); invcp = 1'b1;
    @(negedge cp); invcp = 1'b0;
    repeat (15) @(negedge cp);
    invcp = 1'b1;
    repeat (6) @(negedge cp);
    n_total++;
    if (chk_cnt !== 8'd6) $display("FAIL drop_chk got=%0d required=6", chk_cnt); else n_pass++;
    n_total++;
    if (s_chk !== 2'd3) $display("FAIL drop_sat_chk got=%0d required=3", s_chk); else n_pass++;
    check_drained("sat");
  endtask

  task automatic test_enable();
    do_reset();
    ff_edge(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) ff_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (chk_cnt !== 8'd1) $display("FAIL en_chk got=%0d required=1", chk_cnt); else n_pass++;
    n_total++;
    if (mode !== 2'b10) $display("FAIL en_mode got=%b required=10", mode); else n_pass++;
    check_drained("en");
    en = 1'b1;
    @(negedge cp);
    invj = 1'b0; invk = 1'b0;
    repeat (3) @(negedge cp);
    invcp = 1'b0;
    q_mon = ~q_obs; invq_mon = q_obs;
    repeat (3) @(negedge cp);
    mon_on = 1'b0;
    #2;
    invclr = 1'b0;
    invcp = 1'b1;
    #1;
    n_total++;
    if ({err, fl, mode, chk_cnt, err_cnt} !== 20'd0)
      $display("FAIL abort_async got=%h required=0", {err, fl, mode, chk_cnt, err_cnt});
    else n_pass++;
    @(negedge cp);
    invclr = 1'b1;
    last_chk = chk_cnt;
    mon_on = 1'b1;
    repeat (15) @(negedge cp);
    n_total++;
    if (chk_cnt !== 8'd0) $display("FAIL abort_chk got=%0d required=0", chk_cnt); else n_pass++;
    n_total++;
    if (err_cnt !== 8'd0) $display("FAIL abort_errcnt got=%0d required=0", err_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_sweep();
    test_fault();
    test_complement();
    test_saturation();
    test_enable();
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
